// File: rtl/snn_sched_pkg.sv
// Shared types for the synapse scheduler: FSM states and the queued event record.
package snn_sched_pkg;

  // Widest source id an event record can carry; the scheduler keeps only the low SW bits.
  localparam int unsigned MaxSrcW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StFire,
    StDone
  } sched_state_e;

  typedef struct packed {
    logic [MaxSrcW-1:0] src_id;
    logic               is_post;
  } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO with a registered occupancy count. Depth must be a power of two >= 2.
module evt_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/synapse_scheduler.sv
// Sweeps the FAN_OUT synapses of each queued source neuron, strobing the synaptic core
// and, for pre-synaptic events, returning the saturated sum of the read efficacies.
module synapse_scheduler
  import snn_sched_pkg::*;
#(
  parameter int unsigned N_SYNAPSES   = 8192,
  parameter int unsigned FAN_OUT      = 64,
  parameter int unsigned EVT_DEPTH    = 8,
  parameter int unsigned WEIGHT_WIDTH = 16,
  parameter int unsigned ACC_WIDTH    = 24,
  localparam int unsigned SW          = $clog2(N_SYNAPSES / FAN_OUT),
  localparam int unsigned AW          = $clog2(N_SYNAPSES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           evt_valid,
  output logic                           evt_ready,
  input  logic [SW-1:0]                  evt_src_id,
  input  logic                           evt_is_post,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [ACC_WIDTH-1:0]    res_sum,
  output logic [SW-1:0]                  res_src_id,
  output logic [AW-1:0]                  syn_addr,
  output logic                           syn_cs,
  output logic                           pre_spike,
  output logic                           post_spike,
  input  logic signed [WEIGHT_WIDTH-1:0] efficacy_in,
  output logic                           busy
);

  localparam int unsigned IW   = $clog2(FAN_OUT);
  localparam int unsigned SumW = ((ACC_WIDTH > WEIGHT_WIDTH) ? ACC_WIDTH : WEIGHT_WIDTH) + 1;
  localparam logic signed [SumW-1:0] AccMax = SumW'({1'b0, {(ACC_WIDTH - 1){1'b1}}});
  localparam logic signed [SumW-1:0] AccMin = ~AccMax;

  sched_state_e                 state_q, state_d;
  logic [SW-1:0]                src_q, src_d;
  logic                         is_post_q, is_post_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sat;
  logic signed [SumW-1:0]       sum_wide;

  evt_t push_data, head_evt;
  logic fifo_full, fifo_empty, fifo_pop;
  logic unused_head;

  assign push_data.src_id  = MaxSrcW'(evt_src_id);
  assign push_data.is_post = evt_is_post;
  assign evt_ready         = !fifo_full;
  assign busy              = (state_q != StIdle) || !fifo_empty;
  // Upper src_id bits of the record are padding beyond SW.
  assign unused_head       = ^head_evt;

  evt_fifo #(
    .Width($bits(evt_t)),
    .Depth(EVT_DEPTH)
  ) u_evt_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (evt_valid),
    .wdata(push_data),
    .pop  (fifo_pop),
    .rdata(head_evt),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Saturating add evaluated wide enough that neither operand can overflow before clamping.
  always_comb begin
    sum_wide = SumW'(acc_q) + SumW'(efficacy_in);
    if (sum_wide > AccMax)      acc_sat = AccMax[ACC_WIDTH-1:0];
    else if (sum_wide < AccMin) acc_sat = AccMin[ACC_WIDTH-1:0];
    else                        acc_sat = sum_wide[ACC_WIDTH-1:0];
  end

  // Next-state and outputs; the address is {src, idx} so it can never leave the block.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    is_post_d  = is_post_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    fifo_pop   = 1'b0;
    syn_addr   = '0;
    syn_cs     = 1'b0;
    pre_spike  = 1'b0;
    post_spike = 1'b0;
    res_valid  = 1'b0;
    res_sum    = '0;
    res_src_id = '0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          src_d     = head_evt.src_id[SW-1:0];
          is_post_d = head_evt.is_post;
          idx_d     = '0;
          acc_d     = '0;
          state_d   = StArm;
        end
      end
      StArm: begin
        syn_addr = AW'({src_q, idx_q});
        state_d  = StFire;
      end
      StFire: begin
        syn_addr   = AW'({src_q, idx_q});
        syn_cs     = 1'b1;
        pre_spike  = !is_post_q;
        post_spike = is_post_q;
        if (!is_post_q) acc_d = acc_sat;
        if (idx_q == IW'(FAN_OUT - 1)) begin
          state_d = is_post_q ? StIdle : StDone;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = StArm;
        end
      end
      StDone: begin
        res_valid  = 1'b1;
        res_sum    = acc_q;
        res_src_id = src_q;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, latched event, sweep index and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      src_q     <= '0;
      is_post_q <= 1'b0;
      idx_q     <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      is_post_q <= is_post_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
    end
  end

endmodule
